ifetch_prefetch: RTL and testbench

Instruction prefetch unit between the core's fetch port and the ROM controller's bus slave port. It issues word-aligned 4-byte read requests over the standard single-cycle req/resp bus protocol and buffers returned words in a small FIFO. It presents them to the core as a valid/ready instruction stream, handles control-flow redirects by flushing, and converts bus faults into tagged fault entries.

---
 rtl/ifetch_prefetch.sv | 204 ++++++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: instruction prefetch unit between the core fetch port and
// the ROM controller bus slave.
//   clk, rstn           clock, synchronous active-low reset
//   redirect/_pc        flush the FIFO and restart fetching at redirect_pc
//   instr_*             valid/ready instruction stream (head of the FIFO)
//   bus_*               single-cycle req/resp read master (4-byte, word aligned)
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'b10
`endif

module ifetch_prefetch #(
    parameter int unsigned            DEPTH    = 4,
    parameter logic [`BUS_WIDTH-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      redirect,
    input  logic [`BUS_WIDTH-1:0]     redirect_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [`BUS_WIDTH-1:0]     instr,
    output logic [`BUS_WIDTH-1:0]     instr_pc,
    output logic                      instr_fault,
    output logic [`BUS_WIDTH-1:0]     bus_addr,
    output logic                      bus_w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] bus_acc,
    output logic [`BUS_WIDTH-1:0]     bus_wdata,
    output logic                      bus_req,
    input  logic                      bus_resp,
    input  logic [`BUS_WIDTH-1:0]     bus_rdata,
    input  logic                      bus_fault
);

    localparam int unsigned DW    = `BUS_WIDTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [DW-1:0]    fetch_pc, fetch_pc_next;
    logic [DW-1:0]    req_pc, req_pc_next;
    logic             inflight, inflight_next;
    logic             discard, discard_next;

    logic [DW-1:0]    fifo_data  [DEPTH];
    logic [DW-1:0]    fifo_pc    [DEPTH];
    logic             fifo_fault [DEPTH];
    logic [PTR_W-1:0] wr_ptr, wr_ptr_next, wr_ptr_b;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0] count, count_next, remain;

    logic             req_ok, req_flt, pop, push_resp, push_flt;
    logic [DW-1:0]    head_data_next, head_pc_next;
    logic             head_fault_next;

    assign bus_w_rb  = 1'b0;
    assign bus_acc   = `BUS_ACC_4B;
    assign bus_wdata = '0;
    assign bus_addr  = fetch_pc;

    // Credit rule: buffered plus in-flight words never exceed the FIFO depth
    assign bus_req = rstn && (state == ST_FETCH) && !redirect
                     && ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));

    // Fetch control: next-state, bus bookkeeping and push decisions
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        inflight_next = inflight;
        discard_next  = discard;
        push_resp     = 1'b0;
        push_flt      = 1'b0;
        pop           = 1'b0;
        req_ok        = bus_req & ~bus_fault;
        req_flt       = bus_req & bus_fault;
        if (redirect) begin
            state_next    = ST_FETCH;
            fetch_pc_next = redirect_pc & ~DW'(3);
            // A response still due next cycle belongs to the old stream
            discard_next  = inflight & ~bus_resp;
            if (bus_resp) begin
                inflight_next = 1'b0;
            end
        end else begin
            pop = instr_valid & instr_ready;
            if (bus_resp) begin
                inflight_next = 1'b0;
                if (discard) begin
                    discard_next = 1'b0;
                end else begin
                    push_resp = 1'b1;
                end
            end
            if (req_ok) begin
                req_pc_next   = fetch_pc;
                fetch_pc_next = fetch_pc + DW'(4);
                inflight_next = 1'b1;
            end
            if (req_flt) begin
                push_flt   = 1'b1;
                state_next = ST_HALT;
            end
        end
    end

    // FIFO pointers and next head; a response and a fault can push together
    always_comb begin
        rd_ptr_next     = rd_ptr + PTR_W'(pop);
        remain          = count - CNT_W'(pop);
        wr_ptr_b        = wr_ptr + PTR_W'(push_resp);
        wr_ptr_next     = wr_ptr_b + PTR_W'(push_flt);
        count_next      = remain + CNT_W'(push_resp) + CNT_W'(push_flt);
        head_data_next  = instr;
        head_pc_next    = instr_pc;
        head_fault_next = instr_fault;
        if (remain != '0) begin
            head_data_next  = fifo_data[rd_ptr_next];
            head_pc_next    = fifo_pc[rd_ptr_next];
            head_fault_next = fifo_fault[rd_ptr_next];
        end else if (push_resp) begin
            head_data_next  = bus_rdata;
            head_pc_next    = req_pc;
            head_fault_next = 1'b0;
        end else if (push_flt) begin
            head_data_next  = '0;
            head_pc_next    = fetch_pc;
            head_fault_next = 1'b1;
        end
        if (redirect) begin
            rd_ptr_next     = '0;
            wr_ptr_next     = '0;
            count_next      = '0;
            head_data_next  = instr;
            head_pc_next    = instr_pc;
            head_fault_next = instr_fault;
        end
    end

    // State and head registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            inflight    <= 1'b0;
            discard     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_fault <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            req_pc      <= req_pc_next;
            inflight    <= inflight_next;
            discard     <= discard_next;
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            instr_valid <= (count_next != '0);
            instr       <= head_data_next;
            instr_pc    <= head_pc_next;
            instr_fault <= head_fault_next;
        end
    end

    // FIFO storage; the fault entry lands after a same-cycle response
    always_ff @(posedge clk) begin
        if (rstn && push_resp) begin
            fifo_data[wr_ptr]  <= bus_rdata;
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_fault[wr_ptr] <= 1'b0;
        end
        if (rstn && push_flt) begin
            fifo_data[wr_ptr_b]  <= '0;
            fifo_pc[wr_ptr_b]    <= fetch_pc;
            fifo_fault[wr_ptr_b] <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Pushing into a full FIFO means the credit rule was broken
    always_ff @(posedge clk) begin
        if (rstn && !redirect) begin
            assert ((32'(count) - 32'(pop) + 32'(push_resp) + 32'(push_flt)) <= DEPTH);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Testbench for ifetch_prefetch: directed per-cycle vector table plus a
// randomized run checked against a stream-level reference model.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'b10
`endif

module tb_ifetch_prefetch;

    logic                      clk = 1'b0;
    logic                      rstn = 1'b0;
    logic                      redirect = 1'b0;
    logic [31:0]               redirect_pc = '0;
    logic                      instr_valid;
    logic                      instr_ready = 1'b0;
    logic [31:0]               instr;
    logic [31:0]               instr_pc;
    logic                      instr_fault;
    logic [31:0]               bus_addr;
    logic                      bus_w_rb;
    logic [`BUS_ACC_WIDTH-1:0] bus_acc;
    logic [31:0]               bus_wdata;
    logic                      bus_req;
    logic                      bus_resp = 1'b0;
    logic [31:0]               bus_rdata = '0;
    logic                      bus_fault;

    logic fault_now = 1'b0;
    logic rand_mode = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifetch_prefetch dut (
        .clk         (clk),
        .rstn        (rstn),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault),
        .bus_addr    (bus_addr),
        .bus_w_rb    (bus_w_rb),
        .bus_acc     (bus_acc),
        .bus_wdata   (bus_wdata),
        .bus_req     (bus_req),
        .bus_resp    (bus_resp),
        .bus_rdata   (bus_rdata),
        .bus_fault   (bus_fault)
    );

    // ROM contents: word i holds i + 0x100
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    // Addresses that fault while randomized mode is on
    function automatic logic rom_bad(input logic [31:0] a);
        return ((a >> 2) % 23) == 17;
    endfunction

    // ROM slave: combinational reject, otherwise data one cycle later
    assign bus_fault = bus_req & (fault_now | (rand_mode & rom_bad(bus_addr)));

    always @(posedge clk) begin
        if (!rstn) bus_resp <= 1'b0;
        else       bus_resp <= bus_req & ~bus_fault;
        bus_rdata <= rom_word(bus_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rd;
        logic [31:0] rpc;
        bit          flt;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        bit          e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rdy, input bit rd, input logic [31:0] rpc, input bit flt,
                                input bit er, input logic [31:0] ea, input bit ev,
                                input logic [31:0] ei, input logic [31:0] ep, input bit ef);
        vec_t v;
        v = '{1'b0, rdy, rd, rpc, flt, er, ea, ev, ei, ep, ef};
        vecs.push_back(v);
    endfunction

    function automatic void cyc(input bit rdy, input bit er, input logic [31:0] ea,
                                input bit ev = 1'b0, input logic [31:0] ei = '0,
                                input logic [31:0] ep = '0);
        add(rdy, 1'b0, '0, 1'b0, er, ea, ev, ei, ep, 1'b0);
    endfunction

    function automatic void add_rst();
        vec_t v;
        v = '{1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0};
        vecs.push_back(v);
    endfunction

    // Two reset cycles; checks the reset-state outputs
    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0; redirect = 1'b0; instr_ready = 1'b0; fault_now = 1'b0;
        @(negedge clk);
        chk("rst_req_low", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_fault", 32'(instr_fault), 32'd0);
        chk("rst_addr", bus_addr, 32'h0000_0000);
        chk("rst_w_rb", 32'(bus_w_rb), 32'd0);
        chk("rst_acc", 32'(bus_acc), 32'(`BUS_ACC_4B));
        chk("rst_wdata", bus_wdata, 32'd0);
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(posedge clk); #1;
        rstn = 1'b1; instr_ready = v.rdy; redirect = v.rd; redirect_pc = v.rpc; fault_now = v.flt;
        @(negedge clk);
        chk($sformatf("v%0d_req", idx), 32'(bus_req), 32'(v.e_req));
        chk($sformatf("v%0d_addr", idx), bus_addr, v.e_addr);
        chk($sformatf("v%0d_valid", idx), 32'(instr_valid), 32'(v.e_valid));
        if (v.e_valid) begin
            chk($sformatf("v%0d_instr", idx), instr, v.e_instr);
            chk($sformatf("v%0d_pc", idx), instr_pc, v.e_pc);
            chk($sformatf("v%0d_fault", idx), 32'(instr_fault), 32'(v.e_fault));
        end
    endtask

    // Randomized run against a stream-level model
    task automatic run_random(input int cycles);
        logic [31:0] exp_fetch;
        logic [31:0] exp_del;
        logic [31:0] prev_instr;
        logic        req_halt;
        logic        prev_valid;
        int          n_deliv;
        exp_fetch  = 32'h0;
        exp_del    = 32'h0;
        req_halt   = 1'b0;
        prev_valid = 1'b0;
        prev_instr = '0;
        n_deliv    = 0;
        rand_mode  = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            rstn        = 1'b1;
            fault_now   = 1'b0;
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 99) < 3);
            redirect_pc = 32'($urandom_range(0, 511));
            @(negedge clk);
            if (!prev_valid && !instr_valid) chk("rnd_hold", instr, prev_instr);
            prev_valid = instr_valid;
            prev_instr = instr;
            if (redirect) begin
                chk("rnd_redir_noreq", 32'(bus_req), 32'd0);
                exp_fetch = redirect_pc & ~32'h3;
                exp_del   = exp_fetch;
                req_halt  = 1'b0;
            end else begin
                if (req_halt) begin
                    chk("rnd_req_in_halt", 32'(bus_req), 32'd0);
                end else if (bus_req) begin
                    chk("rnd_addr", bus_addr, exp_fetch);
                    if (rom_bad(exp_fetch)) req_halt = 1'b1;
                    else                    exp_fetch = exp_fetch + 32'd4;
                end
                if (instr_valid && instr_ready) begin
                    chk("rnd_pc", instr_pc, exp_del);
                    chk("rnd_fault", 32'(instr_fault), 32'(rom_bad(exp_del)));
                    chk("rnd_instr", instr, rom_bad(exp_del) ? 32'd0 : rom_word(exp_del));
                    n_deliv++;
                    // Nothing may follow a fault entry until the next redirect
                    exp_del = rom_bad(exp_del) ? 32'hFFFF_FFFF : exp_del + 32'd4;
                end
            end
        end
        chk("rnd_progress", 32'(n_deliv > 300), 32'd1);
        rand_mode = 1'b0;
    endtask

    initial begin
        // Streaming with an always-ready consumer
        add_rst();
        for (int k = 1; k <= 6; k++)
            cyc(1'b1, 1'b1, 32'(4 * (k - 1)), k >= 3, 32'h100 + 32'(k - 3), 32'(4 * (k - 3)));

        // Stalled consumer fills the FIFO, then drains in order
        add_rst();
        cyc(1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b1, 32'h4);
        cyc(1'b0, 1'b1, 32'h8, 1'b1, 32'h100, 32'h0);
        cyc(1'b0, 1'b1, 32'hC, 1'b1, 32'h100, 32'h0);
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 32'h10, 1'b1, 32'h100, 32'h0);
        cyc(1'b1, 1'b0, 32'h10, 1'b1, 32'h100, 32'h0);
        cyc(1'b1, 1'b1, 32'h10, 1'b1, 32'h101, 32'h4);
        cyc(1'b1, 1'b1, 32'h14, 1'b1, 32'h102, 32'h8);
        cyc(1'b1, 1'b1, 32'h18, 1'b1, 32'h103, 32'hC);
        cyc(1'b1, 1'b1, 32'h1C, 1'b1, 32'h104, 32'h10);

        // Redirect to 0x43 with the 0x8 response and a pop in the same cycle
        add_rst();
        cyc(1'b1, 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 32'h4);
        cyc(1'b1, 1'b1, 32'h8, 1'b1, 32'h100, 32'h0);
        add(1'b1, 1'b1, 32'h43, 1'b0, 1'b0, 32'hC, 1'b1, 32'h101, 32'h4, 1'b0);
        cyc(1'b1, 1'b1, 32'h40);
        cyc(1'b1, 1'b1, 32'h44);
        cyc(1'b1, 1'b1, 32'h48, 1'b1, 32'h110, 32'h40);
        cyc(1'b1, 1'b1, 32'h4C, 1'b1, 32'h111, 32'h44);

        // Bus fault on 0x20, halt, then redirect to 0x0
        add_rst();
        for (int k = 1; k <= 8; k++)
            cyc(1'b1, 1'b1, 32'(4 * (k - 1)), k >= 3, 32'h100 + 32'(k - 3), 32'(4 * (k - 3)));
        add(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h106, 32'h18, 1'b0);
        cyc(1'b1, 1'b0, 32'h20, 1'b1, 32'h107, 32'h1C);
        add(1'b1, 1'b0, '0, 1'b0, 1'b0, 32'h20, 1'b1, 32'h0, 32'h20, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 32'h20);
        add(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h20, 1'b0, '0, '0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 32'h4);
        cyc(1'b1, 1'b1, 32'h8, 1'b1, 32'h100, 32'h0);

        // Reset while a request is in flight and stale entries are buffered
        add_rst();
        cyc(1'b0, 1'b1, 32'h0);
        add(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h4, 1'b0, '0, '0, 1'b0);
        cyc(1'b0, 1'b1, 32'h80);
        cyc(1'b0, 1'b1, 32'h84);
        cyc(1'b0, 1'b1, 32'h88, 1'b1, 32'h120, 32'h80);
        add_rst();
        cyc(1'b1, 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 32'h4);
        cyc(1'b1, 1'b1, 32'h8, 1'b1, 32'h100, 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            else             apply(i, vecs[i]);
        end

        do_reset();
        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
